// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 Hz raster constants for the timing generator and renderers.
package vga_timing_pkg;

    localparam int COUNT_W     = 10;
    localparam int CLK_DIV     = 4;

    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_ACT_START = 144;
    localparam int H_ACT_END   = 784;

    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_ACT_START = 35;
    localparam int V_ACT_END   = 515;

    typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator drives it, renderers consume it.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic   hSync;
    logic   vSync;
    logic   bright;
    count_t hCount;
    count_t vCount;
    logic   pix_en;
    logic   frame_tick;

    modport master (output hSync, vSync, bright, hCount, vCount, pix_en, frame_tick);
    modport slave  (input  hSync, vSync, bright, hCount, vCount, pix_en, frame_tick);

endinterface

// File: rtl/vga_timing_gen_pix_clk_en.sv
// Pixel-rate enable: a wrapping divide-by-DIV counter with a one-clk strobe
// on its last phase. DIV must be at least 2.
module pix_clk_en #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div;

    // Phase counter 0..DIV-1, restarting from 0 on reset.
    always_ff @(posedge clk) begin
        if (rst)              div <= '0;
        else if (div == LAST) div <= '0;
        else                  div <= div + DW'(1);
    end

    assign pix_en = (div == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, registered syncs, display-active
// flag and a once-per-frame tick at the start of vertical blank.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = vga_timing_pkg::CLK_DIV,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_ACT_START = vga_timing_pkg::H_ACT_START,
    parameter int H_ACT_END   = vga_timing_pkg::H_ACT_END,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_ACT_START = vga_timing_pkg::V_ACT_START,
    parameter int V_ACT_END   = vga_timing_pkg::V_ACT_END
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);

    // Bounds pre-cast to counter width so every compare is plain unsigned.
    localparam count_t H_LAST   = count_t'(H_TOTAL - 1);
    localparam count_t V_LAST   = count_t'(V_TOTAL - 1);
    localparam count_t H_SYNC_C = count_t'(H_SYNC);
    localparam count_t V_SYNC_C = count_t'(V_SYNC);
    localparam count_t HA_START = count_t'(H_ACT_START);
    localparam count_t HA_END   = count_t'(H_ACT_END);
    localparam count_t VA_START = count_t'(V_ACT_START);
    localparam count_t VA_LAST  = count_t'(V_ACT_END - 1);

    logic   pix_en;
    count_t h_cnt, v_cnt, h_next, v_next;
    logic   h_sync, v_sync, bright, frame_tick;

    pix_clk_en #(.DIV(CLK_DIV)) u_pix_clk_en (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en)
    );

    // Next raster position; line and frame wrap share one edge.
    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_next = '0;
                v_next = (v_cnt == V_LAST) ? '0 : v_cnt + count_t'(1);
            end else begin
                h_next = h_cnt + count_t'(1);
            end
        end
    end

    // Counters plus decodes taken from next-state values, so the syncs and
    // bright always describe the counter value they are registered alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            h_sync     <= 1'b0;
            v_sync     <= 1'b0;
            bright     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            h_cnt      <= h_next;
            v_cnt      <= v_next;
            h_sync     <= !(h_next < H_SYNC_C);
            v_sync     <= !(v_next < V_SYNC_C);
            bright     <= (h_next >= HA_START) && (h_next < HA_END) &&
                          (v_next >= VA_START) && (v_next <= VA_LAST);
            // Only the edge entering (0, V_ACT_END) raises the tick.
            frame_tick <= pix_en && (h_cnt == H_LAST) && (v_cnt == VA_LAST);
        end
    end

    assign vga.hCount     = h_cnt;
    assign vga.vCount     = v_cnt;
    assign vga.hSync      = h_sync;
    assign vga.vSync      = v_sync;
    assign vga.bright     = bright;
    assign vga.pix_en     = pix_en;
    assign vga.frame_tick = frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size generator for reset/line/mid-line reset, and a
// shrunken-raster instance for bright/vSync/frame wrap/frame_tick.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    // Small raster: 20 px x 12 lines, 2 clks/px -> 480 clks/frame.
    localparam int S_DIV = 2;
    localparam int S_HT  = 20;
    localparam int S_HS  = 3;
    localparam int S_HA0 = 5;
    localparam int S_HA1 = 17;
    localparam int S_VT  = 12;
    localparam int S_VS  = 2;
    localparam int S_VA0 = 3;
    localparam int S_VA1 = 10;
    localparam int S_FRAME = S_HT * S_VT * S_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_s = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if vga ();
    vga_timing_gen_if vgs ();

    vga_timing_gen dut (
        .clk (clk),
        .rst (rst),
        .vga (vga)
    );

    vga_timing_gen #(
        .CLK_DIV(S_DIV), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_ACT_START(S_HA0),
        .H_ACT_END(S_HA1), .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_ACT_START(S_VA0),
        .V_ACT_END(S_VA1)
    ) dut_s (
        .clk (clk),
        .rst (rst_s),
        .vga (vgs)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if ({vga.hSync, vga.vSync, vga.bright, vga.pix_en, vga.frame_tick} !== 5'b0 ||
                vga.hCount !== 10'd0 || vga.vCount !== 10'd0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: h=%0d v=%0d flags=%b expected all 0", i,
                         vga.hCount, vga.vCount,
                         {vga.hSync, vga.vSync, vga.bright, vga.pix_en, vga.frame_tick});
            end
        end
        rst = 1'b0;
        step();
        tests++;
        if ({vga.hSync, vga.vSync, vga.bright, vga.pix_en, vga.frame_tick} !== 5'b0 ||
            vga.hCount !== 10'd0) begin
            fails++;
            $display("FAIL reset_after: h=%0d flags=%b expected all 0", vga.hCount,
                     {vga.hSync, vga.vSync, vga.bright, vga.pix_en, vga.frame_tick});
        end
        step();
        tests++;
        if (vga.pix_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_pix_en_early: pix_en=%b expected 0", vga.pix_en);
        end
        step();
        tests++;
        if (vga.pix_en !== 1'b1 || vga.hCount !== 10'd0) begin
            fails++;
            $display("FAIL reset_first_pix_en: pix_en=%b h=%0d expected 1, 0", vga.pix_en, vga.hCount);
        end
        step();
        tests++;
        if (vga.pix_en !== 1'b0 || vga.hCount !== 10'd1) begin
            fails++;
            $display("FAIL reset_first_step: pix_en=%b h=%0d expected 0, 1", vga.pix_en, vga.hCount);
        end
    endtask

    task automatic test_line();
        int bad = 0;
        int first_bad = -1;
        int hs_lo = 0;
        int hs_hi = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3200; c++) begin
            if (vga.hCount !== 10'(c / 4) || vga.vCount !== 10'd0 ||
                vga.pix_en !== ((c % 4) == 3) || vga.hSync !== ((c / 4) >= H_SYNC) ||
                vga.bright !== 1'b0 || vga.vSync !== 1'b0) begin
                if (first_bad < 0) first_bad = c;
                bad++;
            end
            if (vga.hSync === 1'b0) hs_lo++;
            else hs_hi++;
            step();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL line_sequence: %0d bad cycles, first at %0d, expected 0", bad, first_bad);
        end
        tests++;
        if (hs_lo != 384 || hs_hi != 2816) begin
            fails++;
            $display("FAIL line_hsync_width: low=%0d high=%0d expected 384, 2816", hs_lo, hs_hi);
        end
        tests++;
        if (vga.hCount !== 10'd0 || vga.vCount !== 10'd1) begin
            fails++;
            $display("FAIL line_wrap: h=%0d v=%0d expected 0, 1", vga.hCount, vga.vCount);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        while (vga.hCount !== 10'd400 && n < 2000) begin
            step();
            n++;
        end
        tests++;
        if (n >= 2000) begin
            fails++;
            $display("FAIL midrst_reach: h=%0d after %0d cycles expected 400", vga.hCount, n);
        end
        step();
        step();
        tests++;
        if (vga.hCount !== 10'd400 || vga.pix_en !== 1'b0 || vga.hSync !== 1'b1) begin
            fails++;
            $display("FAIL midrst_phase: h=%0d pix_en=%b hSync=%b expected 400, 0, 1",
                     vga.hCount, vga.pix_en, vga.hSync);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if ({vga.hSync, vga.vSync, vga.bright, vga.pix_en, vga.frame_tick} !== 5'b0 ||
            vga.hCount !== 10'd0 || vga.vCount !== 10'd0) begin
            fails++;
            $display("FAIL midrst_clear: h=%0d v=%0d flags=%b expected all 0", vga.hCount,
                     vga.vCount, {vga.hSync, vga.vSync, vga.bright, vga.pix_en, vga.frame_tick});
        end
        step();
        step();
        step();
        tests++;
        if (vga.pix_en !== 1'b1 || vga.hCount !== 10'd0) begin
            fails++;
            $display("FAIL midrst_first_pix_en: pix_en=%b h=%0d expected 1, 0", vga.pix_en, vga.hCount);
        end
        step();
        tests++;
        if (vga.hCount !== 10'd1 || vga.vCount !== 10'd0) begin
            fails++;
            $display("FAIL midrst_restart: h=%0d v=%0d expected 1, 0", vga.hCount, vga.vCount);
        end
    endtask

    task automatic test_bright();
        int   bad = 0;
        int   row_lo_hi = 0;
        int   row_hi_hi = 0;
        logic b_at [S_HT];
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        for (int c = 0; c < S_FRAME; c++) begin
            int h = (c / S_DIV) % S_HT;
            int v = (c / S_DIV) / S_HT;
            logic exp_b = (h >= S_HA0) && (h < S_HA1) && (v >= S_VA0) && (v < S_VA1);
            if (vgs.bright !== exp_b) bad++;
            if (v == S_VA0 && (c % S_DIV) == 0) b_at[h] = vgs.bright;
            if (v == S_VA0 - 1 && vgs.bright === 1'b1) row_lo_hi++;
            if (v == S_VA1 && vgs.bright === 1'b1) row_hi_hi++;
            step();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bright_sweep: %0d bad cycles expected 0", bad);
        end
        tests++;
        if (b_at[S_HA0-1] !== 1'b0 || b_at[S_HA0] !== 1'b1 ||
            b_at[S_HA1-1] !== 1'b1 || b_at[S_HA1] !== 1'b0) begin
            fails++;
            $display("FAIL bright_edges: got %b%b%b%b expected 0110", b_at[S_HA0-1], b_at[S_HA0],
                     b_at[S_HA1-1], b_at[S_HA1]);
        end
        tests++;
        if (row_lo_hi != 0 || row_hi_hi != 0) begin
            fails++;
            $display("FAIL bright_blank_rows: above=%0d below=%0d expected 0, 0", row_lo_hi, row_hi_hi);
        end
    endtask

    task automatic test_frame();
        int bad = 0;
        int first_bad = -1;
        int vs_lo = 0;
        int ticks = 0;
        int tick_at0 = -1;
        int tick_at1 = -1;
        int tick_bright = 0;
        logic [9:0] h_last = '0;
        logic [9:0] v_last = '0;
        logic [9:0] h_wrap = '1;
        logic [9:0] v_wrap = '1;
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        for (int c = 0; c < 2 * S_FRAME; c++) begin
            int p = c / S_DIV;
            int h = p % S_HT;
            int v = (p / S_HT) % S_VT;
            if (vgs.hCount !== 10'(h) || vgs.vCount !== 10'(v) ||
                vgs.hSync !== (h >= S_HS) || vgs.vSync !== (v >= S_VS) ||
                vgs.pix_en !== ((c % S_DIV) == S_DIV - 1) ||
                vgs.frame_tick !== ((c % S_FRAME) == S_VA1 * S_HT * S_DIV)) begin
                if (first_bad < 0) first_bad = c;
                bad++;
            end
            if (vgs.vSync === 1'b0) vs_lo++;
            if (vgs.frame_tick === 1'b1) begin
                ticks++;
                if (tick_at0 < 0) tick_at0 = c;
                else tick_at1 = c;
                if (vgs.bright !== 1'b0) tick_bright++;
            end
            if (c == S_FRAME - 1) begin
                h_last = vgs.hCount;
                v_last = vgs.vCount;
            end
            if (c == S_FRAME) begin
                h_wrap = vgs.hCount;
                v_wrap = vgs.vCount;
            end
            step();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL frame_sequence: %0d bad cycles, first at %0d, expected 0", bad, first_bad);
        end
        tests++;
        if (vs_lo != 2 * S_VS * S_HT * S_DIV) begin
            fails++;
            $display("FAIL frame_vsync_width: low=%0d expected %0d", vs_lo, 2 * S_VS * S_HT * S_DIV);
        end
        tests++;
        if (h_last !== 10'd19 || v_last !== 10'd11 || h_wrap !== 10'd0 || v_wrap !== 10'd0) begin
            fails++;
            $display("FAIL frame_wrap: (%0d,%0d)->(%0d,%0d) expected (19,11)->(0,0)",
                     h_last, v_last, h_wrap, v_wrap);
        end
        tests++;
        if (ticks != 2 || tick_at0 != 400 || tick_at1 - tick_at0 != S_FRAME) begin
            fails++;
            $display("FAIL frame_tick: count=%0d first=%0d period=%0d expected 2, 400, %0d",
                     ticks, tick_at0, tick_at1 - tick_at0, S_FRAME);
        end
        tests++;
        if (tick_bright != 0) begin
            fails++;
            $display("FAIL frame_tick_bright: %0d ticks during bright expected 0", tick_bright);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_mid_reset();
        test_bright();
        test_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
